// File: rtl/bsw_banded.sv
// bsw_banded: banded Smith-Waterman scorer with affine gaps; each new symbol pair
// extends the band by one row (s index n) and one column (t index n) in a single cycle.
module bsw_banded #(
    parameter int SEQ_LEN   = 256,
    parameter int HALF_BAND = 8,
    parameter int MATCH     = 8,
    parameter int MISMATCH  = 5,
    parameter int GAP_OPEN  = 7,
    parameter int GAP_EXT   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [1:0]  data_s,
    input  logic [1:0]  data_t,
    output logic        finish,
    output logic [11:0] max
);
    typedef logic signed [12:0] sc_t;
    localparam int B = HALF_BAND;
    localparam int CW = $clog2(SEQ_LEN);
    localparam sc_t NEG = -13'sd1024;
    localparam sc_t GO = sc_t'(GAP_OPEN);
    localparam sc_t GE = sc_t'(GAP_EXT);
    localparam sc_t MA = sc_t'(MATCH);
    localparam sc_t MI = sc_t'(MISMATCH);

    function automatic sc_t mx(input sc_t a, input sc_t b);
        return a > b ? a : b;
    endfunction

    function automatic sc_t sub(input logic eq);
        return eq ? MA : -MI;
    endfunction

    // row_*[d] = cell (n, n-d), col_*[d] = cell (n-d, n); index 0 is the diagonal corner
    sc_t row_h [0:B];
    sc_t row_f [0:B];
    sc_t col_h [0:B];
    sc_t col_e [0:B];
    logic [1:0] s_hist [0:B-1];
    logic [1:0] t_hist [0:B-1];
    logic [CW-1:0] cnt;
    logic [11:0] best;

    sc_t nr_h [1:B+1];
    sc_t nr_e [1:B+1];
    sc_t nr_f [1:B];
    sc_t nc_h [1:B+1];
    sc_t nc_f [1:B+1];
    sc_t nc_e [1:B];
    sc_t ce, cf, ch, diag0, m;

    always_comb begin
        nr_h[B+1] = '0;
        nr_e[B+1] = NEG;
        nc_h[B+1] = '0;
        nc_f[B+1] = NEG;
        for (int d = B; d >= 1; d--) begin
            if (32'(cnt) >= d) begin
                nr_e[d] = mx(nr_h[d+1] - GO, nr_e[d+1] - GE);
                nr_f[d] = mx(row_h[d-1] - GO, row_f[d-1] - GE);
                nr_h[d] = mx(mx('0, row_h[d] + sub(data_s == t_hist[d-1])), mx(nr_e[d], nr_f[d]));
                nc_f[d] = mx(nc_h[d+1] - GO, nc_f[d+1] - GE);
                nc_e[d] = mx(col_h[d-1] - GO, col_e[d-1] - GE);
                nc_h[d] = mx(mx('0, col_h[d] + sub(s_hist[d-1] == data_t)), mx(nc_e[d], nc_f[d]));
            end else begin
                nr_e[d] = NEG;
                nr_f[d] = NEG;
                nr_h[d] = '0;
                nc_f[d] = NEG;
                nc_e[d] = NEG;
                nc_h[d] = '0;
            end
        end
        // cnt==0 marks the first symbol of a job: the old corner belongs to a previous job
        diag0 = cnt == '0 ? '0 : row_h[0];
        ce = mx(nr_h[1] - GO, nr_e[1] - GE);
        cf = mx(nc_h[1] - GO, nc_f[1] - GE);
        ch = mx(mx('0, diag0 + sub(data_s == data_t)), mx(ce, cf));
        m = cnt == '0 ? '0 : $signed({1'b0, best});
        m = mx(m, ch);
        for (int d = 1; d <= B; d++)
            m = mx(m, mx(nr_h[d], nc_h[d]));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            finish <= 1'b0;
            cnt    <= '0;
            best   <= '0;
            for (int d = 0; d <= B; d++) begin
                row_h[d] <= '0;
                row_f[d] <= NEG;
                col_h[d] <= '0;
                col_e[d] <= NEG;
            end
            for (int d = 0; d < B; d++) begin
                s_hist[d] <= '0;
                t_hist[d] <= '0;
            end
        end else begin
            finish <= i_valid && cnt == CW'(SEQ_LEN - 1);
            if (i_valid) begin
                cnt      <= cnt == CW'(SEQ_LEN - 1) ? '0 : cnt + 1'b1;
                best     <= m[12] ? '0 : m[11:0];
                row_h[0] <= ch;
                row_f[0] <= cf;
                col_h[0] <= ch;
                col_e[0] <= ce;
                for (int d = 1; d <= B; d++) begin
                    row_h[d] <= nr_h[d];
                    row_f[d] <= nr_f[d];
                    col_h[d] <= nc_h[d];
                    col_e[d] <= nc_e[d];
                end
                s_hist[0] <= data_s;
                t_hist[0] <= data_t;
                for (int d = 1; d < B; d++) begin
                    s_hist[d] <= s_hist[d-1];
                    t_hist[d] <= t_hist[d-1];
                end
            end
        end
    end

    assign max = best;
endmodule

// File: tb/tb_bsw_banded.sv
// tb_bsw_banded: directed jobs with hand-computed best scores, pulse counts and latency.
module tb_bsw_banded;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_valid = 1'b0;
    logic [1:0] data_s = '0;
    logic [1:0] data_t = '0;
    logic finish;
    logic [11:0] max;
    int checks = 0;
    int fails = 0;
    logic [1:0] sa [256];
    logic [1:0] ta [256];

    always #5 clk = ~clk;

    bsw_banded dut (
        .clk(clk), .reset(reset), .i_valid(i_valid),
        .data_s(data_s), .data_t(data_t), .finish(finish), .max(max)
    );

    task automatic set_seqs(input int m);
        for (int k = 0; k < 256; k++) begin
            case (m)
                0: begin sa[k] = 2'd0; ta[k] = 2'd0; end
                1: begin sa[k] = 2'd0; ta[k] = 2'd1; end
                2: begin sa[k] = 2'd0; ta[k] = (k == 128) ? 2'd2 : 2'd0; end
                3: begin sa[k] = 2'(k % 4); ta[k] = 2'((k + 1) % 4); end
                4: begin sa[k] = 2'd3; ta[k] = 2'd3; end
                default: begin sa[k] = 2'd2; ta[k] = 2'd2; end
            endcase
        end
    endtask

    task automatic run_job(input int gap_at, output int pulses, output int lat, output logic [11:0] score);
        pulses = 0;
        lat = -1;
        score = '0;
        for (int k = 0; k < 256; k++) begin
            if (k == gap_at)
                repeat (3) begin
                    @(negedge clk);
                    if (finish) pulses++;
                    i_valid = 1'b0;
                    data_s = 2'd3;
                    data_t = 2'd1;
                end
            @(negedge clk);
            if (finish) pulses++;
            i_valid = 1'b1;
            data_s = sa[k];
            data_t = ta[k];
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (finish) begin
                pulses++;
                if (lat < 0) begin
                    lat = c + 1;
                    score = max;
                end
            end
            i_valid = 1'b0;
            data_s = 2'(c);
            data_t = 2'(c + 1);
            if (lat >= 0 && c >= lat + 1) break;
        end
    endtask

    task automatic check_job(input string name, input int gap_at, input logic [11:0] exp);
        int pulses, lat;
        logic [11:0] score;
        run_job(gap_at, pulses, lat, score);
        checks += 3;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL %s pulses: got %0d expected 1", name, pulses);
        end
        if (lat < 1 || lat > 24) begin
            fails++;
            $display("FAIL %s latency: got %0d expected 1..24", name, lat);
        end
        if (score !== exp) begin
            fails++;
            $display("FAIL %s max: got %0d expected %0d", name, score, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (finish !== 1'b0) begin
            fails++;
            $display("FAIL reset finish: got %b expected 0", finish);
        end
        if (max !== 12'd0) begin
            fails++;
            $display("FAIL reset max: got %0d expected 0", max);
        end
    endtask

    task automatic test_basic;
        set_seqs(0); check_job("all_a", -1, 12'd2048);
        set_seqs(1); check_job("a_vs_c", -1, 12'd0);
        set_seqs(2); check_job("one_mismatch", -1, 12'd2035);
        set_seqs(3); check_job("offset_diag", -1, 12'd2040);
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        set_seqs(0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (finish) pulses++;
            i_valid = 1'b1;
            data_s = sa[k];
            data_t = ta[k];
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (finish) pulses++;
        end
        checks += 2;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL abort pulses: got %0d expected 0", pulses);
        end
        if (max !== 12'd0) begin
            fails++;
            $display("FAIL abort max: got %0d expected 0", max);
        end
        set_seqs(4);
        check_job("after_abort", -1, 12'd2048);
    endtask

    task automatic test_pause;
        set_seqs(5);
        check_job("paused", 77, 12'd2048);
    endtask

    task automatic test_back_to_back;
        set_seqs(0); check_job("b2b_first", -1, 12'd2048);
        set_seqs(1); check_job("b2b_second", -1, 12'd0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_reset_mid;
        test_pause;
        test_back_to_back;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
